// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and default geometry for the cache-line <-> memory-burst adaptor.
//   adaptor_state_e : FSM encoding
//   BEATS / BEAT_IDX_W / OFFSET_W : derived from the default 256-bit line, 64-bit beat
package cacheline_adaptor_pkg;
  localparam int LINE_W_DEF  = 256;
  localparam int BURST_W_DEF = 64;
  localparam int ADDR_W_DEF  = 32;

  localparam int BEATS      = LINE_W_DEF / BURST_W_DEF;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam int OFFSET_W   = $clog2(LINE_W_DEF / 8);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_BURST = 3'd1,
    RD_DONE  = 3'd2,
    WR_BURST = 3'd3,
    WR_DONE  = 3'd4
  } adaptor_state_e;
endpackage

// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between cache (line side) and main memory (burst side).
//   Cache side : line_i, address_i, read_i, write_i -> adaptor; line_o, resp_o <- adaptor
//   Memory side: burst_i, resp_i -> adaptor; burst_o, address_o, read_o, write_o <- adaptor
//   modport slave  : the adaptor's view
//   modport master : the environment's view (cache + memory)
interface cacheline_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
);
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor_line_beat_buffer.sv
// Line-wide register organised as BEATS beat slots.
//   load/load_line        : parallel load of a whole line (write-back capture)
//   wr_en/wr_idx/wr_beat  : store one beat into slot wr_idx (read fill)
//   rd_idx/rd_beat        : beat-indexed read mux (write-back streaming)
//   line                  : whole buffer, beat 0 in the low bits
// Parallel load has priority over a beat write.
module line_beat_buffer #(
  parameter  int LINE_W  = 256,
  parameter  int BURST_W = 64,
  localparam int NB      = LINE_W / BURST_W,
  localparam int IDX_W   = $clog2(NB)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [LINE_W-1:0]  load_line,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [BURST_W-1:0] wr_beat,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [BURST_W-1:0] rd_beat,
  output logic [LINE_W-1:0]  line
);
  logic [NB-1:0][BURST_W-1:0] mem;

  for (genvar b = 0; b < NB; b++) begin : g_slot
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                 mem[b] <= '0;
      else if (load)                            mem[b] <= load_line[b*BURST_W +: BURST_W];
      else if (wr_en && wr_idx == IDX_W'(b))    mem[b] <= wr_beat;
    end
  end

  assign rd_beat = mem[rd_idx];
  assign line    = mem;
endmodule

// File: rtl/cacheline_adaptor.sv
// Memory-side responder for the cache pmem port. Turns one whole-line read or
// write request into a BEATS-long burst on the memory port and answers the
// cache with a single-cycle resp_o.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : cacheline_adaptor_if.slave (cache line side + memory burst side)
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input logic              clk,
  input logic              rst,
  cacheline_adaptor_if.slave bus
);
  localparam int NB    = LINE_W / BURST_W;
  localparam int IDX_W = $clog2(NB);
  localparam int OFF_W = $clog2(LINE_W / 8);

  adaptor_state_e      state, state_nxt;
  logic [IDX_W-1:0]    k;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   fill_q;
  logic [LINE_W-1:0]   buf_line;
  logic [BURST_W-1:0]  buf_beat;
  logic                in_burst, last_beat, take_req, buf_load, buf_wr;
  logic                unused_addr_lsb;

  assign in_burst  = (state == RD_BURST) || (state == WR_BURST);
  assign last_beat = bus.resp_i && (k == IDX_W'(NB - 1));
  assign take_req  = (state == IDLE) && (bus.read_i || bus.write_i);
  // Read wins when both are requested, so the line is only captured for a pure write.
  assign buf_load  = (state == IDLE) && !bus.read_i && bus.write_i;
  assign buf_wr    = (state == RD_BURST) && bus.resp_i;
  assign unused_addr_lsb = ^bus.address_i[OFF_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.read_i)       state_nxt = RD_BURST;
                else if (bus.write_i) state_nxt = WR_BURST;
      RD_BURST: if (last_beat)        state_nxt = RD_DONE;
      RD_DONE:                        state_nxt = IDLE;
      WR_BURST: if (last_beat)        state_nxt = WR_DONE;
      WR_DONE:                        state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Beat counter: advances only on strobes inside a burst and wraps to 0 on the
  // last beat; held at 0 everywhere else so strobes outside a burst are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      k <= '0;
    else if (in_burst && bus.resp_i) k <= k + 1'b1;
    else if (!in_burst)            k <= '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          addr_q <= '0;
    else if (take_req) addr_q <= {bus.address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  // The buffer is reused by later bursts, so the completed fill is copied out in
  // RD_DONE and line_o holds that copy until the next read completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  fill_q <= '0;
    else if (state == RD_DONE) fill_q <= buf_line;
  end

  line_beat_buffer #(.LINE_W(LINE_W), .BURST_W(BURST_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_line (bus.line_i),
    .wr_en     (buf_wr),
    .wr_idx    (k),
    .wr_beat   (bus.burst_i),
    .rd_idx    (k),
    .rd_beat   (buf_beat),
    .line      (buf_line)
  );

  assign bus.read_o    = (state == RD_BURST);
  assign bus.write_o   = (state == WR_BURST);
  assign bus.resp_o    = (state == RD_DONE) || (state == WR_DONE);
  assign bus.address_o = addr_q;
  assign bus.burst_o   = (state == WR_BURST) ? buf_beat : '0;
  assign bus.line_o    = (state == RD_DONE) ? buf_line : fill_q;
endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;

  typedef struct {
    bit          rd;
    bit          wr_too;
    logic [31:0] addr;
    logic [LW-1:0] line;
    logic [15:0] pat;       // resp_i per burst cycle, LSB first; all ones past bit 15
    bit          spur;      // strobe resp_i in IDLE/DONE cycles
    logic [31:0] exp_addr;
    int          exp_busy;  // cycles read_o/write_o stays high
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [LW-1:0] rd_q[$];
  logic [BW-1:0] wr_q[$];

  always #5 clk = ~clk;

  cacheline_adaptor_if #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)) bus ();

  cacheline_adaptor #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One whole transaction: request in IDLE, drive/observe the burst, check resp_o.
  // With wr_too the task stops in the resp_o cycle and leaves write_i asserted.
  task automatic run_txn(input vec_t v, output int busy);
    int k;
    int n;
    bit r;
    if (v.rd) begin
      bus.read_i = 1'b1;
      rd_q.push_back(v.line);
      if (!v.wr_too) bus.line_i = ~v.line;
      else           bus.write_i = 1'b1;
    end else begin
      bus.write_i = 1'b1;
      bus.line_i  = v.line;
      for (int b = 0; b < BEATS; b++) wr_q.push_back(v.line[b*BW +: BW]);
    end
    bus.address_i = v.addr;
    bus.resp_i    = v.spur;
    bus.burst_i   = {$urandom, $urandom};
    tick();
    chk("address_o", 256'(bus.address_o), 256'(v.exp_addr));
    // Request-side changes mid-burst must not matter.
    if (!v.wr_too) begin
      bus.address_i = ~v.addr;
      bus.line_i    = ~v.line;
      if (!v.rd) bus.write_i = 1'b0;
    end
    busy = 0; k = 0; n = 0;
    while (busy < 64 && (v.rd ? bus.read_o : bus.write_o)) begin
      r = (n < 16) ? v.pat[n] : 1'b1;
      n++;
      if (v.rd) chk("write_o idle in read", 256'(bus.write_o), 256'(0));
      else begin
        chk("read_o idle in write", 256'(bus.read_o), 256'(0));
        if (wr_q.size() > 0) chk("burst_o beat", 256'(bus.burst_o), 256'(wr_q[0]));
        else begin
          n_chk++; n_fail++;
          $display("FAIL burst_o: extra beat %h offered, none expected", bus.burst_o);
        end
      end
      bus.resp_i  = r;
      bus.burst_i = (r && k < BEATS) ? v.line[k*BW +: BW] : {$urandom, $urandom};
      tick();
      busy++;
      if (r) begin
        k++;
        if (!v.rd && wr_q.size() > 0) void'(wr_q.pop_front());
      end
    end
    chk("burst cycles", 256'(busy), 256'(v.exp_busy));
    chk("resp_o pulse", 256'(bus.resp_o), 256'(1));
    if (v.rd) begin
      if (rd_q.size() > 0) chk("line_o fill", bus.line_o, rd_q.pop_front());
      else begin
        n_chk++; n_fail++;
        $display("FAIL line_o: resp_o with no read outstanding, got %h", bus.line_o);
      end
    end else chk("write beats left", 256'(wr_q.size()), 256'(0));
    bus.read_i  = 1'b0;
    bus.write_i = v.wr_too;
    bus.resp_i  = v.spur;
    bus.burst_i = {$urandom, $urandom};
    if (!v.wr_too) begin
      tick();
      chk("resp_o after", 256'(bus.resp_o), 256'(0));
      chk("read_o after", 256'(bus.read_o), 256'(0));
      chk("write_o after", 256'(bus.write_o), 256'(0));
      chk("burst_o idle", 256'(bus.burst_o), 256'(0));
      if (v.rd) chk("line_o held", bus.line_o, v.line);
      bus.resp_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    int   busy;

    vecs[0] = '{rd: 1, wr_too: 0, addr: 32'h0000_1234,
                line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                pat: 16'hFFFF, spur: 0, exp_addr: 32'h0000_1220, exp_busy: 4};
    vecs[1] = '{rd: 0, wr_too: 0, addr: 32'h8000_00E0, line: rnd_line(),
                pat: 16'hFFFF, spur: 0, exp_addr: 32'h8000_00E0, exp_busy: 4};
    vecs[2] = '{rd: 1, wr_too: 0, addr: 32'h0000_0FFF, line: rnd_line(),
                pat: 16'h0069, spur: 0, exp_addr: 32'h0000_0FE0, exp_busy: 7};
    vecs[3] = '{rd: 0, wr_too: 0, addr: 32'h1234_5678, line: rnd_line(),
                pat: 16'h00A5, spur: 1, exp_addr: 32'h1234_5660, exp_busy: 8};
    vecs[4] = '{rd: 1, wr_too: 0, addr: 32'hDEAD_BEEF, line: rnd_line(),
                pat: 16'hFFFF, spur: 1, exp_addr: 32'hDEAD_BEE0, exp_busy: 4};
    vecs[5] = '{rd: 1, wr_too: 0, addr: 32'h0000_003F, line: rnd_line(),
                pat: 16'hFFFF, spur: 1, exp_addr: 32'h0000_0020, exp_busy: 4};

    bus.line_i = '0; bus.address_i = '0; bus.read_i = 0; bus.write_i = 0;
    bus.burst_i = '0; bus.resp_i = 0;
    rst = 1'b0;
    tick(); tick();
    chk("reset resp_o", 256'(bus.resp_o), 256'(0));
    chk("reset read_o", 256'(bus.read_o), 256'(0));
    chk("reset write_o", 256'(bus.write_o), 256'(0));
    chk("reset address_o", 256'(bus.address_o), 256'(0));
    chk("reset burst_o", 256'(bus.burst_o), 256'(0));
    chk("reset line_o", bus.line_o, '0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], busy);
      // request cycle + burst cycles + resp cycle, counting the request cycle as 1
      if (i == 0) chk("read latency", 256'(busy + 2), 256'(6));
    end

    // Read and write both requested: read first, write launched from the IDLE
    // cycle that follows resp_o.
    bus.line_i = rnd_line();
    v = '{rd: 1, wr_too: 1, addr: 32'h0000_A5A5, line: rnd_line(),
          pat: 16'hFFFF, spur: 0, exp_addr: 32'h0000_A5A0, exp_busy: 4};
    run_txn(v, busy);
    tick();
    chk("idle after rd resp", 256'(bus.write_o | bus.resp_o), 256'(0));
    chk("line_o after rd", bus.line_o, v.line);
    v = '{rd: 0, wr_too: 0, addr: 32'h0000_A5A5, line: bus.line_i,
          pat: 16'hFFFF, spur: 0, exp_addr: 32'h0000_A5A0, exp_busy: 4};
    run_txn(v, busy);

    // Asynchronous reset after two beats of a read.
    bus.read_i = 1'b1; bus.address_i = 32'h0000_4444;
    tick();
    for (int b = 0; b < 2; b++) begin
      bus.resp_i = 1'b1; bus.burst_i = {$urandom, $urandom};
      tick();
    end
    bus.resp_i = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("mid-reset read_o", 256'(bus.read_o), 256'(0));
    chk("mid-reset resp_o", 256'(bus.resp_o), 256'(0));
    chk("mid-reset line_o", bus.line_o, '0);
    chk("mid-reset address_o", 256'(bus.address_o), 256'(0));
    bus.read_i = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("post-reset resp_o", 256'(bus.resp_o), 256'(0));
    v = '{rd: 1, wr_too: 0, addr: 32'h0000_4444, line: rnd_line(),
          pat: 16'hFFFF, spur: 0, exp_addr: 32'h0000_4440, exp_busy: 4};
    run_txn(v, busy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
